// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: fixed-latency mult/div with a busy
// window, direct HI/LO writes (mthi/mtlo) and combinational reads (mfhi/mflo).
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilowe,
    input  logic        hilo_A3,
    input  logic [31:0] wd,
    input  logic [1:0]  re_hi_lo,
    output logic        busy,
    output logic [31:0] hilo_rd
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo, p_hi, p_lo;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [31:0] res_hi, res_lo;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division runs on magnitudes so 0x80000000 / -1 never overflows;
    // the divisor is forced to 1 when zero to keep the divider defined.
    always_comb begin
        div_signed = ~md_op[0];
        a_mag      = (div_signed && A[31]) ? (-A) : A;
        b_mag      = (div_signed && B[31]) ? (-B) : B;
        b_safe     = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quo        = (div_signed && (A[31] ^ B[31])) ? (-q_mag) : q_mag;
        rem        = (div_signed && A[31]) ? (-r_mag) : r_mag;
        res_hi     = hi;
        res_lo     = lo;
        case (md_op)
            2'b00: {res_hi, res_lo} = prod_s;
            2'b01: {res_hi, res_lo} = prod_u;
            default: begin
                if (B != '0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        p_hi  <= res_hi;
                        p_lo  <= res_lo;
                        cnt   <= md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (hilowe) begin
                        if (hilo_A3) lo <= wd;
                        else         hi <= wd;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= p_hi;
                        lo    <= p_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (re_hi_lo)
            2'b01:   hilo_rd = hi;
            2'b10:   hilo_rd = lo;
            default: hilo_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table of mult/div operations plus
// hand-written busy-window, write-ignore and asynchronous reset sequences.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] A, B;
    logic        hilowe;
    logic        hilo_A3;
    logic [31:0] wd;
    logic [1:0]  re_hi_lo;
    logic        busy;
    logic [31:0] hilo_rd;

    int n_cmp = 0;
    int n_err = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .hilowe   (hilowe),
        .hilo_A3  (hilo_A3),
        .wd       (wd),
        .re_hi_lo (re_hi_lo),
        .busy     (busy),
        .hilo_rd  (hilo_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hi(output logic [31:0] v);
        re_hi_lo = 2'b01;
        #1 v = hilo_rd;
    endtask

    task automatic read_lo(output logic [31:0] v);
        re_hi_lo = 2'b10;
        #1 v = hilo_rd;
    endtask

    // Called one time unit after a rising edge; returns the same way.
    task automatic write_hilo(input logic sel, input logic [31:0] d);
        hilowe  = 1'b1;
        hilo_A3 = sel;
        wd      = d;
        @(posedge clk); #1;
        hilowe  = 1'b0;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts busy cycles until busy falls, checking that HI reads the old value meanwhile.
    task automatic wait_idle(input string name, input logic [31:0] old_hi, output int cycles);
        logic [31:0] v;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            read_hi(v);
            chk({name, " hi during busy"}, v, old_hi);
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          cyc;
        int          exp_n;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022};
        vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000};
        vecs[5]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h0, 32'h0, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000};
        vecs[8]  = '{2'b10, 32'h00000005, 32'h00000000, 32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB};
        vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{2'b00, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000};

        reset = 1'b1; start = 1'b0; md_op = 2'b00; A = '0; B = '0;
        hilowe = 1'b0; hilo_A3 = 1'b0; wd = '0; re_hi_lo = 2'b00;

        #2;
        chk("reset busy", {31'd0, busy}, 32'd0);
        read_hi(v); chk("reset hi", v, 32'h0);
        read_lo(v); chk("reset lo", v, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First start right after reset release; HI must read 0 while busy.
        launch(2'b00, 32'h00000003, 32'h00000004);
        wait_idle("first", 32'h0, cyc);
        chk("first busy len", cyc, 32'd5);
        read_lo(v); chk("first lo", v, 32'd12);

        for (int i = 0; i < 11; i++) begin
            write_hilo(1'b0, vecs[i].pre_hi);
            write_hilo(1'b1, vecs[i].pre_lo);
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle($sformatf("vec%0d", i), vecs[i].pre_hi, cyc);
            exp_n = vecs[i].op[1] ? 10 : 5;
            chk($sformatf("vec%0d busy len", i), cyc, exp_n);
            read_hi(v); chk($sformatf("vec%0d hi", i), v, vecs[i].exp_hi);
            read_lo(v); chk($sformatf("vec%0d lo", i), v, vecs[i].exp_lo);
        end

        // mthi then mfhi, and unmapped read selects return 0.
        write_hilo(1'b0, 32'h12345678);
        read_hi(v); chk("mthi read", v, 32'h12345678);
        re_hi_lo = 2'b00; #1 chk("rsel 00", hilo_rd, 32'h0);
        re_hi_lo = 2'b11; #1 chk("rsel 11", hilo_rd, 32'h0);

        // mthi and a second start (div) during a mult: both ignored, original 5-cycle schedule kept.
        launch(2'b01, 32'h00000003, 32'h00000004);
        hilowe = 1'b1; hilo_A3 = 1'b0; wd = 32'hDEADBEEF;
        start = 1'b1; md_op = 2'b10; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        hilowe = 1'b0; start = 1'b0;
        read_hi(v); chk("mthi while busy", v, 32'h12345678);
        wait_idle("restart", 32'h12345678, cyc);
        chk("restart busy len", cyc, 32'd4);
        read_hi(v); chk("restart hi", v, 32'h0);
        read_lo(v); chk("restart lo", v, 32'd12);

        // start and mtlo together in IDLE: start wins.
        write_hilo(1'b1, 32'h77);
        hilowe = 1'b1; hilo_A3 = 1'b1; wd = 32'h99;
        launch(2'b01, 32'd2, 32'd3);
        hilowe = 1'b0;
        read_lo(v); chk("start wins lo", v, 32'h77);
        wait_idle("startwins", 32'h0, cyc);
        chk("startwins busy len", cyc, 32'd5);
        read_lo(v); chk("startwins lo after", v, 32'd6);

        // Asynchronous reset in busy cycle 4 of a div.
        write_hilo(1'b0, 32'h11);
        write_hilo(1'b1, 32'h22);
        launch(2'b10, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); #1; end
        chk("busy before reset", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1 chk("async reset busy", {31'd0, busy}, 32'd0);
        read_hi(v); chk("async reset hi", v, 32'h0);
        read_lo(v); chk("async reset lo", v, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        chk("post reset busy", {31'd0, busy}, 32'd0);
        read_hi(v); chk("post reset hi", v, 32'h0);
        read_lo(v); chk("post reset lo", v, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
